// File: rtl/phi_pkg.sv
// Shared types and width helpers for the phi accumulator.
// Pure declarations; no timing or backpressure of its own.
package phi_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, MAC} state_e;

  localparam int SAT_W = 128;
  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int sum_width(input int bit_width, input int max_intervals);
    return bit_width + $clog2(max_intervals + 1);
  endfunction

  function automatic int prod_width(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a sign-extended value to the signed range of bit_width bits.
  function automatic wide_t saturate(input wide_t v, input int bit_width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (bit_width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/phi_mac.sv
// Registered signed MAC with clear; result = sat((acc + a*b) >>> FRAC_BITS), combinational.
// One product per enabled cycle; accumulator clears on clr_i or after the last term; no backpressure.
module phi_mac
  import phi_pkg::*;
#(
  parameter int A_W       = 32,
  parameter int B_W       = 40,
  parameter int NTERMS    = 3,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             last_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [OUT_W-1:0] res_o,
  output logic             clip_o
);

  localparam int PROD_W = prod_width(A_W, B_W);
  localparam int ACC_W  = PROD_W + idx_width(NTERMS);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] a_ext, b_ext, total, shifted;
  wide_t                   sat_in, sat_out;

  always_comb begin
    a_ext   = ACC_W'($signed(a_i));
    b_ext   = ACC_W'($signed(b_i));
    total   = acc_q + a_ext * b_ext;
    shifted = total >>> FRAC_BITS;
    sat_in  = SAT_W'(shifted);
    sat_out = saturate(sat_in, OUT_W);
    clip_o  = (sat_out != sat_in);
    res_o   = sat_out[OUT_W-1:0];

    acc_d = acc_q;
    if (clr_i || (en_i && last_i)) acc_d = '0;
    else if (en_i)                 acc_d = total;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/phi_accumulator.sv
// Accumulates per-nu T sums over a run, then evaluates FORMANTS weighted phi values on one shared MAC.
// Latency FORMANTS*NU_VALUES cycles from last beat to output_valid; input_ready high only while accumulating.
module phi_accumulator
  import phi_pkg::*;
#(
  parameter int BIT_WIDTH     = 32,
  parameter int FORMANTS      = 5,
  parameter int NU_VALUES     = 3,
  parameter int MAX_INTERVALS = 160,
  parameter int FRAC_BITS     = 8
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic [NU_VALUES-1:0][BIT_WIDTH-1:0]           T_vals,
  input  logic [FORMANTS-1:0][NU_VALUES-1:0][BIT_WIDTH-1:0] coef,
  input  logic                                          input_start,
  input  logic                                          input_valid,
  input  logic                                          input_last,
  output logic                                          input_ready,
  output logic                                          busy,
  output logic [FORMANTS-1:0][BIT_WIDTH-1:0]            output_data,
  output logic                                          output_valid,
  output logic                                          overflow,
  output logic                                          saturated
);

  localparam int SUM_W = sum_width(BIT_WIDTH, MAX_INTERVALS);
  localparam int CNT_W = $clog2(MAX_INTERVALS + 1);
  localparam int F_W   = idx_width(FORMANTS);
  localparam int NU_W  = idx_width(NU_VALUES);

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     count_q, count_d;
  logic signed [SUM_W-1:0]              sum_q [NU_VALUES];
  logic signed [SUM_W-1:0]              sum_d [NU_VALUES];
  logic [F_W-1:0]                       f_q, f_d;
  logic [NU_W-1:0]                      nu_q, nu_d;
  logic [FORMANTS-1:0][BIT_WIDTH-1:0]   shadow_q, shadow_d;
  logic [FORMANTS-1:0][BIT_WIDTH-1:0]   out_q, out_d;
  logic                                 vld_q, vld_d;
  logic                                 ovf_q, ovf_d;
  logic                                 sat_q, sat_d;

  logic                 run_clr, mac_clr, mac_en, mac_last, mac_clip;
  logic [BIT_WIDTH-1:0] mac_res;
  logic [SUM_W-1:0]     mac_b;

  assign mac_b = sum_q[nu_q];

  phi_mac #(
    .A_W      (BIT_WIDTH),
    .B_W      (SUM_W),
    .NTERMS   (NU_VALUES),
    .OUT_W    (BIT_WIDTH),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .last_i(mac_last),
    .a_i   (coef[f_q][nu_q]),
    .b_i   (mac_b),
    .res_o (mac_res),
    .clip_o(mac_clip)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sum_d    = sum_q;
    f_d      = f_q;
    nu_d     = nu_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    vld_d    = 1'b0;
    ovf_d    = ovf_q;
    sat_d    = sat_q;
    run_clr  = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;

    case (state_q)
      IDLE: begin
        if (input_start) begin
          state_d = ACCUM;
          run_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (input_start) begin
          run_clr = 1'b1;
        end else if (input_valid) begin
          if (count_q < CNT_W'(MAX_INTERVALS)) begin
            for (int n = 0; n < NU_VALUES; n++)
              sum_d[n] = sum_q[n] + SUM_W'($signed(T_vals[n]));
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (input_last) begin
            state_d = MAC;
            f_d     = '0;
            nu_d    = '0;
            mac_clr = 1'b1;
          end
        end
      end
      MAC: begin
        if (input_start) begin
          state_d = ACCUM;
          run_clr = 1'b1;
        end else begin
          mac_en = 1'b1;
          if (nu_q == NU_W'(NU_VALUES - 1)) begin
            mac_last         = 1'b1;
            shadow_d[f_q]    = mac_res;
            sat_d            = sat_q | mac_clip;
            nu_d             = '0;
            if (f_q == F_W'(FORMANTS - 1)) begin
              // Final pair: publish shadow including this cycle's result.
              out_d      = shadow_q;
              out_d[f_q] = mac_res;
              vld_d      = 1'b1;
              state_d    = IDLE;
            end else begin
              f_d = f_q + F_W'(1);
            end
          end else begin
            nu_d = nu_q + NU_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (run_clr) begin
      for (int n = 0; n < NU_VALUES; n++) sum_d[n] = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      sat_d   = 1'b0;
      mac_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      count_q  <= '0;
      for (int n = 0; n < NU_VALUES; n++) sum_q[n] <= '0;
      f_q      <= '0;
      nu_q     <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      f_q      <= f_d;
      nu_q     <= nu_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  assign input_ready  = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign output_data  = out_q;
  assign output_valid = vld_q;
  assign overflow     = ovf_q;
  assign saturated    = sat_q;

endmodule

// File: tb/tb_phi_accumulator.sv
// Directed bench for phi_accumulator with hand-computed expectations.
module tb_phi_accumulator;
  localparam int BW = 32, NF = 5, NU = 3, MAXI = 160, FB = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NU-1:0][BW-1:0]         t_vals;
  logic [NF-1:0][NU-1:0][BW-1:0] coef;
  logic input_start, input_valid, input_last;
  logic input_ready, busy, output_valid, overflow, saturated;
  logic [NF-1:0][BW-1:0] output_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phi_accumulator #(
    .BIT_WIDTH(BW), .FORMANTS(NF), .NU_VALUES(NU),
    .MAX_INTERVALS(MAXI), .FRAC_BITS(FB)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .T_vals      (t_vals),
    .coef        (coef),
    .input_start (input_start),
    .input_valid (input_valid),
    .input_last  (input_last),
    .input_ready (input_ready),
    .busy        (busy),
    .output_data (output_data),
    .output_valid(output_valid),
    .overflow    (overflow),
    .saturated   (saturated)
  );

  task automatic set_coef_uniform(input logic [BW-1:0] v);
    for (int f = 0; f < NF; f++)
      for (int n = 0; n < NU; n++) coef[f][n] = v;
  endtask

  task automatic pulse_start();
    input_start = 1'b1;
    @(posedge clk); #1;
    input_start = 1'b0;
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [BW-1:0] c, input logic last);
    t_vals[0] = a; t_vals[1] = b; t_vals[2] = c;
    input_valid = 1'b1;
    input_last  = last;
    @(posedge clk); #1;
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask

  // Returns the number of edges until output_valid is seen, 0 on timeout.
  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (output_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    input_start = 1'b0; input_valid = 1'b0; input_last = 1'b0;
    t_vals = '0; coef = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", output_valid); end
    n_cmp++; if (input_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", input_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL reset_saturated: got %b want 0", saturated); end
    n_cmp++; if (output_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", output_data); end
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    set_coef_uniform(32'd256);
    pulse_start();
    n_cmp++; if (input_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_on: got %b want 1", input_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_on: got %b want 1", busy); end
    send_beat(1, 2, 3, 1'b0);
    send_beat(1, 2, 3, 1'b0);
    send_beat(1, 2, 3, 1'b1);
    n_cmp++; if (input_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_off: got %b want 0", input_ready); end
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL basic_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'd18) begin n_bad++; $display("FAIL basic_data[%0d]: got %0d want 18", f, $signed(output_data[f])); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL basic_saturated: got %b want 0", saturated); end
    @(posedge clk); #1;
    n_cmp++; if (output_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width: got %b want 0", output_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_off: got %b want 0", busy); end
  endtask

  task automatic test_weighting();
    int cyc;
    logic [BW-1:0] exp_v;
    coef = '0;
    for (int f = 0; f < NF; f++) coef[f][0] = 256 * (f + 1);
    pulse_start();
    send_beat(-4, 7, 9, 1'b0);
    send_beat(-4, 7, 9, 1'b1);
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL weight_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      exp_v = -8 * (f + 1);
      n_cmp++; if (output_data[f] !== exp_v) begin n_bad++; $display("FAIL weight_data[%0d]: got %0d want %0d", f, $signed(output_data[f]), $signed(exp_v)); end
    end
    // -(f+1)/256 must floor to -1, not truncate to 0.
    coef = '0;
    for (int f = 0; f < NF; f++) coef[f][0] = f + 1;
    pulse_start();
    send_beat(-1, 0, 0, 1'b1);
    wait_valid(40, cyc);
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL floor_data[%0d]: got %0d want -1", f, $signed(output_data[f])); end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    set_coef_uniform(32'd512);
    pulse_start();
    send_beat(32'h7FFF_FFFF, 0, 0, 1'b1);
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL sat_pos_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_pos_data[%0d]: got %h want 7fffffff", f, output_data[f]); end
    end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL sat_pos_flag: got %b want 1", saturated); end
    pulse_start();
    n_cmp++; if (saturated !== 1'b0) begin n_bad++; $display("FAIL sat_clear_on_start: got %b want 0", saturated); end
    send_beat(32'h8000_0000, 0, 0, 1'b1);
    wait_valid(40, cyc);
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'h8000_0000) begin n_bad++; $display("FAIL sat_neg_data[%0d]: got %h want 80000000", f, output_data[f]); end
    end
    n_cmp++; if (saturated !== 1'b1) begin n_bad++; $display("FAIL sat_neg_flag: got %b want 1", saturated); end
  endtask

  task automatic test_overflow();
    int cyc;
    set_coef_uniform(32'd256);
    pulse_start();
    for (int k = 1; k <= MAXI; k++) send_beat(1, 1, 1, k == MAXI);
    wait_valid(40, cyc);
    n_cmp++; if (output_data[0] !== 32'd480) begin n_bad++; $display("FAIL full_data: got %0d want 480", $signed(output_data[0])); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_overflow: got %b want 0", overflow); end
    pulse_start();
    for (int k = 1; k <= MAXI + 2; k++) begin
      send_beat(1, 1, 1, k == MAXI + 2);
      if (k == MAXI) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_max: got %b want 0", overflow); end
      end
      if (k == MAXI + 1) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_past_max: got %b want 1", overflow); end
      end
    end
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL ovf_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'd480) begin n_bad++; $display("FAIL ovf_data[%0d]: got %0d want 480", f, $signed(output_data[f])); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    set_coef_uniform(32'd256);
    pulse_start();
    send_beat(5, 5, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    n_cmp++; if (input_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", input_ready); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (output_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
    n_cmp++; if (output_data[0] !== 32'd480) begin n_bad++; $display("FAIL abort_data_kept: got %0d want 480", $signed(output_data[0])); end
    // Start and a beat together: the beat must be discarded.
    t_vals[0] = 100; t_vals[1] = 100; t_vals[2] = 100;
    input_start = 1'b1; input_valid = 1'b1;
    @(posedge clk); #1;
    input_start = 1'b0; input_valid = 1'b0;
    send_beat(2, 0, 0, 1'b1);
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL abort_rerun_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'd2) begin n_bad++; $display("FAIL abort_rerun_data[%0d]: got %0d want 2", f, $signed(output_data[f])); end
    end
    // Beats while idle are ignored.
    t_vals[0] = 50;
    input_valid = 1'b1; input_last = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin input_valid = 1'b0; input_last = 1'b0; end
      if (output_valid || busy) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL idle_valid_ignored: got %0d active cycles want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int pulses;
    set_coef_uniform(32'd256);
    pulse_start();
    send_beat(7, 7, 7, 1'b0);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (output_data !== '0) begin n_bad++; $display("FAIL rstmid_data: got %h want 0", output_data); end
    n_cmp++; if (input_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", input_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    pulses = 0;
    t_vals[0] = 9; input_valid = 1'b1; input_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      input_valid = 1'b0; input_last = 1'b0;
      if (output_valid || busy) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_ignored: got %0d active cycles want 0", pulses); end
    pulse_start();
    send_beat(2, 0, 0, 1'b1);
    wait_valid(40, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL rstmid_rerun_latency: got %0d want 15", cyc); end
    for (int f = 0; f < NF; f++) begin
      n_cmp++; if (output_data[f] !== 32'd2) begin n_bad++; $display("FAIL rstmid_rerun_data[%0d]: got %0d want 2", f, $signed(output_data[f])); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_weighting();
    test_saturation();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
